// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall control: load-use and branch-operand bubbles, mult/div occupancy, data-memory freeze with timeout abort.
// Enables are combinational from inputs and state; only the memory wait FSM and the mult/div counter are registered.
module hazard_stall_ctrl #(
    parameter int MD_LAT      = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_branch,
    input  logic       id_branch_taken,
    input  logic       id_md_start,
    input  logic       id_md_read,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dst,
    input  logic       mem_mem_read,
    input  logic       mem_mem_write,
    input  logic [4:0] mem_dst,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       if_id_wr,
    output logic       flush_if_id,
    output logic       id_ex_wr,
    output logic       stall1,
    output logic       stall2,
    output logic       ex_mem_wr,
    output logic       mem_wb_wr,
    output logic       md_busy,
    output logic       mem_err
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_ABORT = 1'b1;

    localparam logic [3:0] MD_LAT_V  = 4'(MD_LAT);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [0:0] state;
    logic [7:0] wait_cnt;
    logic [3:0] md_cnt;

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_hz;
    logic md_hz;
    logic freeze;
    logic md_issue;

    // Register zero is never a real dependency.
    function automatic logic reg_match(input logic uses, input logic [4:0] src, input logic [4:0] dst);
        return uses && (src == dst) && (dst != 5'd0);
    endfunction

    assign ex_hit   = reg_match(id_uses_rs, id_rs, ex_dst)  || reg_match(id_uses_rt, id_rt, ex_dst);
    assign mem_hit  = reg_match(id_uses_rs, id_rs, mem_dst) || reg_match(id_uses_rt, id_rt, mem_dst);
    assign md_busy  = (md_cnt != 4'd0);
    assign load_use = ex_mem_read && ex_hit;
    assign br_hz    = id_branch && ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit));
    assign md_hz    = md_busy && (id_md_read || id_md_start);
    assign freeze   = (state == ST_RUN) && (mem_mem_read || mem_mem_write) && !mem_ready;
    assign mem_err  = (state == ST_ABORT);

    always_comb begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_wr    = 1'b0;
        ex_mem_wr   = 1'b0;
        mem_wb_wr   = 1'b0;
        stall1      = 1'b0;
        stall2      = 1'b0;
        flush_if_id = 1'b0;
        if (!freeze) begin
            stall1      = load_use;
            stall2      = !load_use && (br_hz || md_hz);
            pc_wr       = !(stall1 || stall2);
            if_id_wr    = !(stall1 || stall2);
            id_ex_wr    = 1'b1;
            ex_mem_wr   = 1'b1;
            // An aborted access must not reach write-back.
            mem_wb_wr   = (state != ST_ABORT);
            flush_if_id = id_branch_taken && !stall1 && !stall2;
        end
    end

    assign md_issue = id_md_start && id_ex_wr && !stall1 && !stall2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
            md_cnt   <= 4'd0;
        end else begin
            if (state == ST_ABORT) begin
                state    <= ST_RUN;
                wait_cnt <= 8'd0;
            end else if (freeze) begin
                if (wait_cnt == WAIT_LAST) begin
                    state    <= ST_ABORT;
                    wait_cnt <= 8'd0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end

            // The unit keeps counting through a freeze; it runs on its own.
            if (md_issue)
                md_cnt <= MD_LAT_V;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int MD_LAT      = 8;
    localparam int MEM_TIMEOUT = 16;
    localparam logic [9:0] RESET_OUTS = 10'b11_0_1_00_11_00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic       id_uses_rs, id_uses_rt, id_branch, id_branch_taken;
    logic       id_md_start, id_md_read, ex_reg_write, ex_mem_read;
    logic       mem_mem_read, mem_mem_write, mem_ready;
    logic       pc_wr, if_id_wr, flush_if_id, id_ex_wr, stall1, stall2;
    logic       ex_mem_wr, mem_wb_wr, md_busy, mem_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: remaining mult/div cycles, consecutive wait cycles, abort cycle pending.
    int md_left   = 0;
    int waited    = 0;
    bit in_abort  = 0;

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_dst(mem_dst),
        .mem_ready(mem_ready),
        .pc_wr(pc_wr), .if_id_wr(if_id_wr), .flush_if_id(flush_if_id), .id_ex_wr(id_ex_wr),
        .stall1(stall1), .stall2(stall2), .ex_mem_wr(ex_mem_wr), .mem_wb_wr(mem_wb_wr),
        .md_busy(md_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {pc_wr, if_id_wr, flush_if_id, id_ex_wr, stall1, stall2,
                ex_mem_wr, mem_wb_wr, md_busy, mem_err};
    endfunction

    function automatic bit depends(input logic [4:0] dst);
        return (dst != 0) && ((id_uses_rs && id_rs == dst) || (id_uses_rt && id_rt == dst));
    endfunction

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_branch = 0; id_branch_taken = 0; id_md_start = 0; id_md_read = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0;
        mem_mem_read = 0; mem_mem_write = 0; mem_dst = 0; mem_ready = 1;
    endtask

    // Compare against the model, then take one clock edge and advance the model.
    task automatic step();
        bit frz, busy, lu, bh, mh, s1, s2;
        logic [9:0] exp;
        #2;
        busy = (md_left > 0);
        frz  = !in_abort && (mem_mem_read || mem_mem_write) && !mem_ready;
        lu   = ex_mem_read && depends(ex_dst);
        bh   = id_branch && ((ex_reg_write && depends(ex_dst)) || (mem_mem_read && depends(mem_dst)));
        mh   = busy && (id_md_read || id_md_start);
        s1   = !frz && lu;
        s2   = !frz && !lu && (bh || mh);
        if (frz)
            exp = {8'b0, busy, 1'b0};
        else
            exp = {!(s1 || s2), !(s1 || s2), id_branch_taken && !s1 && !s2, 1'b1, s1, s2,
                   1'b1, !in_abort, busy, in_abort};
        check("outs", 32'(outs()), 32'(exp));
        @(posedge clk);
        if (in_abort) begin
            in_abort = 0;
            waited   = 0;
        end else if (frz) begin
            if (waited + 1 == MEM_TIMEOUT) begin
                in_abort = 1;
                waited   = 0;
            end else begin
                waited++;
            end
        end else begin
            waited = 0;
        end
        if (!frz && !s1 && !s2 && id_md_start) md_left = MD_LAT;
        else if (md_left > 0) md_left--;
        #1;
    endtask

    task automatic rand_inputs(input int low_pct, input bit force_mem);
        id_rs           = 5'($urandom_range(3));
        id_rt           = 5'($urandom_range(3));
        ex_dst          = 5'($urandom_range(3));
        mem_dst         = 5'($urandom_range(3));
        id_uses_rs      = 1'($urandom_range(1));
        id_uses_rt      = 1'($urandom_range(1));
        id_branch       = ($urandom_range(99) < 30);
        id_branch_taken = ($urandom_range(99) < 20);
        id_md_start     = ($urandom_range(99) < 10);
        id_md_read      = ($urandom_range(99) < 15);
        ex_reg_write    = 1'($urandom_range(1));
        ex_mem_read     = ($urandom_range(99) < 30);
        mem_mem_read    = force_mem || ($urandom_range(99) < 40);
        mem_mem_write   = !mem_mem_read && ($urandom_range(99) < 30);
        mem_ready       = !($urandom_range(99) < low_pct);
    endtask

    initial begin
        int cnt;
        bit seen;
        idle();
        #2;
        check("reset_outs_in_rst", 32'(outs()), 32'(RESET_OUTS));
        #14 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outs", 32'(outs()), 32'(RESET_OUTS));
        step();

        // Load-use: lw $3 in EX, consumer of $3 in ID.
        ex_mem_read = 1; ex_dst = 3; id_rs = 3; id_uses_rs = 1;
        #1;
        check("lu_stall1", 32'(stall1), 1);
        check("lu_pc_wr", 32'(pc_wr), 0);
        check("lu_if_id_wr", 32'(if_id_wr), 0);
        check("lu_id_ex_wr", 32'(id_ex_wr), 1);
        step();
        idle(); step();

        // Branch operand from EX, then from a load in MEM, then only $0.
        id_branch = 1; id_rs = 5; id_uses_rs = 1; ex_reg_write = 1; ex_dst = 5;
        #1; check("br_ex_stall2", 32'(stall2), 1); step();
        ex_reg_write = 0; ex_dst = 0; mem_mem_read = 1; mem_dst = 5;
        #1; check("br_mem_stall2", 32'(stall2), 1); step();
        idle(); id_branch = 1; id_uses_rs = 1; ex_reg_write = 1;
        #1; check("br_r0_stall2", 32'(stall2), 0); step();
        idle(); step();

        // mult issue, then mfhi waits out the whole latency.
        id_md_start = 1; step();
        id_md_start = 0; id_md_read = 1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!md_busy) break;
            if (stall2) cnt++;
            step();
        end
        check("md_stall_cycles", 32'(cnt), MD_LAT);
        check("mfhi_proceeds", 32'({md_busy, stall2, pc_wr}), 32'(3'b001));
        step();
        idle(); step();

        // Short memory wait.
        mem_mem_read = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1; check("wait_frozen", 32'({pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr}), 0);
            step();
        end
        mem_ready = 1;
        #1; check("wait_resume", 32'({pc_wr, mem_wb_wr, mem_err}), 32'(3'b110));
        step();

        // Timeout abort.
        mem_ready = 0; cnt = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mem_err) begin seen = 1; break; end
            if (!pc_wr && !mem_wb_wr) cnt++;
            step();
        end
        check("abort_seen", 32'(seen), 1);
        check("freeze_cycles", 32'(cnt), MEM_TIMEOUT);
        check("abort_enables", 32'({pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr}), 32'(5'b11110));
        step();
        #1; check("abort_one_cycle", 32'(mem_err), 0);
        step();
        idle(); step();

        // Flush on taken branch, suppressed by a load-use bubble.
        id_branch_taken = 1;
        #1; check("flush_clean", 32'({flush_if_id, pc_wr}), 32'(2'b11)); step();
        ex_mem_read = 1; ex_dst = 7; id_rt = 7; id_uses_rt = 1;
        #1; check("flush_lu", 32'({flush_if_id, stall1}), 32'(2'b01)); step();
        idle(); step();

        // Reset during freeze with mult/div busy.
        id_md_start = 1; step();
        idle(); mem_mem_read = 1; mem_ready = 0; step(); step();
        rst = 1; idle();
        #1; check("rst_mid_freeze", 32'(outs()), 32'(RESET_OUTS));
        md_left = 0; waited = 0; in_abort = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        step();

        // Random traffic; every fourth block holds the memory in long waits.
        for (int blk = 0; blk < 40; blk++) begin
            for (int k = 0; k < 50; k++) begin
                if (blk % 4 == 3) rand_inputs(97, 1);
                else rand_inputs(20, 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
